uart_rx_fifo: RTL

//  Receive buffer directly downstream of uart_rx. Captures each received word on
//  the uart_rx_ready strobe together with its parity-error flag, stores it in a

---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Stream bundle between uart_rx, the receive FIFO and its consumer.
// The slave side is the FIFO; the master side drives words in and pulls them out.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  rx_error;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_error;
  logic                  m_valid;
  logic                  m_ready;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  overflow_clr;
  logic [7:0]            err_count;

  modport slave (
    input  rx_data, rx_ready, rx_error, m_ready, overflow_clr,
    output m_data, m_error, m_valid, count, full, almost_full, overflow, err_count
  );

  modport master (
    output rx_data, rx_ready, rx_error, m_ready, overflow_clr,
    input  m_data, m_error, m_valid, count, full, almost_full, overflow, err_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: first-word-fall-through head register in front of
// a synchronous-read RAM, with almost_full, sticky overflow and error counting.
module uart_rx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH_LOG2    = 4,
  parameter int AFULL_LEVEL   = 12,
  parameter int DROP_ON_ERROR = 0
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int                  CAP     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CAP_C   = (DEPTH_LOG2+1)'(CAP);
  localparam logic [DEPTH_LOG2:0] AFULL_C = (DEPTH_LOG2+1)'(AFULL_LEVEL);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2+1)'(1);

  logic [DATA_WIDTH:0]   mem [CAP];

  logic [DATA_WIDTH:0]   head_q;
  logic                  m_valid_q, m_valid_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;

  logic                  push, pop, accept, lost, ram_empty;
  logic                  head_load_in, head_load_ram, ram_we;
  logic [DATA_WIDTH:0]   wr_word;

  always_comb begin
    push    = bus.rx_ready && !((DROP_ON_ERROR != 0) && bus.rx_error);
    pop     = m_valid_q && bus.m_ready;
    wr_word = {bus.rx_error, bus.rx_data};
    accept  = push && ((count_q != CAP_C) || pop);
    lost    = push && !accept;
    // The RAM holds every entry except the head, so it is empty while count <= 1.
    ram_empty     = (count_q <= ONE_C);
    head_load_ram = pop && !ram_empty;
    head_load_in  = accept && (!m_valid_q || (pop && ram_empty));
    ram_we        = accept && !head_load_in;
  end

  always_comb begin
    m_valid_d   = m_valid_q;
    count_d     = count_q + (DEPTH_LOG2+1)'(accept) - (DEPTH_LOG2+1)'(pop);
    wr_ptr_d    = wr_ptr_q + DEPTH_LOG2'(ram_we);
    rd_ptr_d    = rd_ptr_q + DEPTH_LOG2'(head_load_ram);
    overflow_d  = overflow_q;
    err_count_d = err_count_q;

    if (head_load_in || head_load_ram) begin
      m_valid_d = 1'b1;
    end else if (pop) begin
      m_valid_d = 1'b0;
    end

    if (lost) begin
      overflow_d = 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_d = 1'b0;
    end

    if (bus.rx_ready && bus.rx_error && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    full_d  = (count_d == CAP_C);
    afull_d = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      err_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      count_q     <= count_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage array is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // Head register doubles as the RAM read register; an incoming word bypasses
  // the RAM only when nothing older is queued behind the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else if (head_load_in) begin
      head_q <= wr_word;
    end else if (head_load_ram) begin
      head_q <= mem[rd_ptr_q];
    end
  end

  assign bus.m_data      = head_q[DATA_WIDTH-1:0];
  assign bus.m_error     = head_q[DATA_WIDTH];
  assign bus.m_valid     = m_valid_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow    = overflow_q;
  assign bus.err_count   = err_count_q;
endmodule
